// File: rtl/spi_pkg.sv
// Shared widths, limits and controller state encoding for the SPI write controller.
package spi_pkg;

    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int FRAME_W  = 16;
    localparam int MAX_ADDR = 4;
    localparam logic WRITE_BIT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_GAP,
        ST_ERR
    } spi_state_e;

    function automatic logic [FRAME_W-1:0] build_frame(input logic [ADDR_W-1:0] addr,
                                                        input logic [DATA_W-1:0] data);
        return {WRITE_BIT, addr, data};
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK phase timer: phase_done strobes on the last cycle of every CLK_DIV-cycle phase while en is high.
module spi_clkgen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic phase_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign phase_done = en && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI write controller: one 16-bit frame {1, addr, data} per accepted request, MSB first.
// Optional SPI_CONTROLLER_ADDR_CHECK_EN rejects addresses above MAX_ADDR with an err pulse.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 8,
    parameter int CS_GAP  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              SCLK,
    output logic              COPI,
    output logic              nCS,
    output logic              done,
    output logic              err
);

    // A request is taken on a rising edge where req_valid && req_ready; req_ready is high only in IDLE.
    localparam int BIT_W = $clog2(FRAME_W);
    localparam int GAP_W = $clog2(CS_GAP);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    spi_state_e         state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               ready_q, ready_d;
    logic               sclk_q, sclk_d;
    logic               copi_q, copi_d;
    logic               ncs_q, ncs_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               phase_en;
    logic               phase_done;
    logic [FRAME_W-1:0] new_frame;
    logic               addr_bad;

    assign phase_en  = (state_q == ST_SETUP) || (state_q == ST_HIGH) || (state_q == ST_LOW);
    assign new_frame = build_frame(req_addr, req_data);

`ifdef SPI_CONTROLLER_ADDR_CHECK_EN
    assign addr_bad = (req_addr > ADDR_W'(MAX_ADDR));
`else
    assign addr_bad = 1'b0;
`endif

    spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (phase_en),
        .phase_done (phase_done)
    );

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        ready_d = ready_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        ncs_d   = ncs_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (req_valid && ready_q) begin
                    ready_d = 1'b0;
                    frame_d = new_frame;
                    if (addr_bad) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        ncs_d   = 1'b0;
                        sclk_d  = 1'b0;
                        copi_d  = new_frame[FRAME_W-1];
                        bit_d   = BIT_W'(FRAME_W - 1);
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            ST_SETUP: begin
                if (phase_done) begin
                    state_d = ST_HIGH;
                    sclk_d  = 1'b1;
                end
            end
            ST_HIGH: begin
                if (phase_done) begin
                    state_d = ST_LOW;
                    sclk_d  = 1'b0;
                    // Bit 0 stays on COPI through the final LOW phase.
                    if (bit_q != '0) begin
                        copi_d = frame_q[bit_q - BIT_W'(1)];
                    end
                end
            end
            ST_LOW: begin
                if (phase_done) begin
                    if (bit_q == '0) begin
                        state_d = ST_GAP;
                        ncs_d   = 1'b1;
                        copi_d  = 1'b0;
                        done_d  = 1'b1;
                        gap_d   = '0;
                    end else begin
                        state_d = ST_HIGH;
                        sclk_d  = 1'b1;
                        bit_d   = bit_q - BIT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            ready_q <= 1'b0;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ncs_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            ncs_q   <= ncs_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = ready_q;
    assign SCLK      = sclk_q;
    assign COPI      = copi_q;
    assign nCS       = ncs_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a sampling SPI peripheral model decodes frames and a scoreboard checks them.
module tb_spi_controller;

    localparam int CLK_DIV = 8;
    localparam int CS_GAP  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [6:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       sclk, copi, ncs, done, err;

    always #5 clk = ~clk;

    spi_controller #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .SCLK      (sclk),
        .COPI      (copi),
        .nCS       (ncs),
        .done      (done),
        .err       (err)
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  per[0:127];
    logic [7:0]  exp_regs[0:127];

    int low_cnt = 0, rises = 0, high_cnt = 0, last_gap = 0;
    int frames = 0, done_cnt = 0, err_cnt = 0;
    logic [15:0] shift = '0;
    logic prev_ncs = 1'b1, prev_sclk = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Peripheral model: samples on the falling clk edge, captures COPI at each SCLK rise.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ncs  = 1'b1;
                prev_sclk = 1'b0;
                low_cnt   = 0;
                rises     = 0;
                shift     = '0;
                high_cnt  = 0;
            end else begin
                if (done) done_cnt++;
                if (err) err_cnt++;
                if (!ncs) begin
                    if (prev_ncs) begin
                        last_gap = high_cnt;
                        low_cnt  = 0;
                        rises    = 0;
                    end
                    low_cnt++;
                    if (sclk && !prev_sclk) begin
                        rises++;
                        shift = {shift[14:0], copi};
                    end
                end else begin
                    if (!prev_ncs) begin
                        frames++;
                        check_eq("frame_expected", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check_eq("frame_bits", shift, e);
                        end
                        check_eq("sclk_rises", rises, 16);
                        check_eq("ncs_low_cycles", low_cnt, 33 * CLK_DIV);
                        check_eq("done_first_gap", done, 1);
                        per[shift[14:8]] = shift[7:0];
                        high_cnt = 0;
                    end
                    high_cnt++;
                end
                prev_ncs  = ncs;
                prev_sclk = sclk;
            end
        end
    end

    task automatic send(input logic [6:0] a, input logic [7:0] d, input bit expect_frame);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("send_ready", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        if (expect_frame) begin
            exp_q.push_back({1'b1, a, d});
            exp_regs[a] = d;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 7'($urandom_range(0, 127));
        req_data  = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_timeout", n < 3000, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int f0, d0, e0;
        for (int i = 0; i < 128; i++) begin
            per[i]      = '0;
            exp_regs[i] = '0;
        end

        repeat (3) @(negedge clk);
        check_eq("rst_ncs", ncs, 1);
        check_eq("rst_sclk", sclk, 0);
        check_eq("rst_copi", copi, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_ready", req_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", req_ready, 1);

        // Basic write
        send(7'd0, 8'hA5, 1);
        wait_idle();
        check_eq("basic_done_cnt", done_cnt, 1);

        // Loopback into the peripheral register model
        send(7'd4, 8'h3C, 1);
        wait_idle();
        for (int i = 0; i < 5; i++) check_eq($sformatf("loop_reg%0d", i), per[i], exp_regs[i]);

        // Back-to-back with req_valid held high
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 7'd1;
        req_data  = 8'h11;
        exp_q.push_back({1'b1, 7'd1, 8'h11});
        exp_regs[1] = 8'h11;
        @(negedge clk);
        req_addr = 7'd2;
        req_data = 8'h22;
        exp_q.push_back({1'b1, 7'd2, 8'h22});
        exp_regs[2] = 8'h22;
        n = 0;
        while (!req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("b2b_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle();
        check_eq("b2b_gap", last_gap, CS_GAP + 1);
        check_eq("b2b_reg1", per[1], 8'h11);
        check_eq("b2b_reg2", per[2], 8'h22);

        // Out-of-range address
        f0 = frames;
        d0 = done_cnt;
`ifdef SPI_CONTROLLER_ADDR_CHECK_EN
        send(7'd5, 8'h5A, 0);
        repeat (40) @(negedge clk);
        check_eq("addr5_err_cnt", err_cnt, 1);
        check_eq("addr5_no_frame", frames, f0);
        check_eq("addr5_no_done", done_cnt, d0);
        check_eq("addr5_ready", req_ready, 1);
`else
        send(7'd5, 8'h5A, 1);
        wait_idle();
        check_eq("addr5_err_cnt", err_cnt, 0);
        check_eq("addr5_frame", frames, f0 + 1);
        check_eq("addr5_reg", per[5], 8'h5A);
`endif

        // Busy ignore
        send(7'd2, 8'h44, 1);
        repeat (50) @(negedge clk);
        check_eq("busy_ready", req_ready, 0);
        req_valid = 1'b1;
        req_addr  = 7'd3;
        req_data  = 8'h99;
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle();
        f0 = frames;
        repeat (60) @(negedge clk);
        check_eq("busy_no_queue", frames, f0);
        check_eq("busy_reg3", per[3], exp_regs[3]);

        // Reset during the 7th HIGH phase
        send(7'd1, 8'hC3, 1);
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (rises != 7 && n < 3000);
        check_eq("rst7_reach", rises, 7);
        #2;
        d0 = done_cnt;
        e0 = err_cnt;
        rst_n = 1'b0;
        #1;
        check_eq("rst7_ncs", ncs, 1);
        check_eq("rst7_sclk", sclk, 0);
        check_eq("rst7_done", done, 0);
        exp_q.delete();
        exp_regs[1] = 8'h11;
        repeat (3) @(negedge clk);
        check_eq("rst7_ready", req_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst7_ready_rise", req_ready, 1);
        send(7'd3, 8'hFF, 1);
        wait_idle();
        check_eq("rst7_no_done", done_cnt, d0 + 1);
        check_eq("rst7_no_err", err_cnt, e0);
        check_eq("post_rst_reg3", per[3], 8'hFF);
        check_eq("aborted_reg1", per[1], exp_regs[1]);

        check_eq("done_per_frame", done_cnt, frames);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 8, giving SCLK half-period in clk cycles (legal minimum 4).
REQ-002 The block SHALL have parameter CS_GAP, default 16, giving the minimum nCS-high cycles between frames (legal minimum 4).
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req_valid  input  1  host write request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_addr  input  7  target register address.
REQ-008 req_data  input  8  byte to write.
REQ-009 SCLK  output  1  serial clock; idles low.
REQ-010 COPI  output  1  serial data to the peripheral.
REQ-011 nCS  output  1  chip select, active-low.
REQ-012 done  output  1  one-cycle pulse when a frame completes.
REQ-013 err  output  1  one-cycle pulse on a rejected request (see Configuration).

Function
REQ-014 Handshake: a request SHALL be accepted on a clk edge where req_valid and req_ready are both high; req_ready SHALL be high only in IDLE.
REQ-015 On accept, the block SHALL latch the 16-bit frame {1'b1, req_addr, req_data}; later changes to the request inputs SHALL not affect the frame.
REQ-016 FSM states SHALL be IDLE -> SETUP -> (HIGH -> LOW) x16 -> GAP -> IDLE.
REQ-017 SETUP: starting the cycle after accept, nCS=0, SCLK=0, and COPI=frame bit 15 for CLK_DIV cycles.
REQ-018 HIGH: SCLK=1 for CLK_DIV cycles with COPI stable.
REQ-019 LOW: SCLK=0 for CLK_DIV cycles; COPI SHALL change to the next bit (MSB first) on the first LOW cycle, except after bit 0, where COPI holds.
REQ-020 nCS SHALL stay low for exactly 33*CLK_DIV cycles with exactly 16 SCLK rising edges, then rise on the cycle after the 16th LOW phase ends.
REQ-021 GAP: nCS=1, SCLK=0, COPI=0 for CS_GAP cycles; done SHALL pulse on the first GAP cycle.
REQ-022 After GAP the block SHALL return to IDLE with req_ready=1; a valid request pending in that cycle SHALL be accepted immediately.
REQ-023 While the block is busy, req_valid SHALL be ignored, with no queueing.
REQ-024 Divider and bit counters SHALL be sized with $clog2 of their parameters; the bit counter SHALL count 15 down to 0 with no wrap.

Reset
REQ-025 While rst_n=0, the outputs SHALL be nCS=1, SCLK=0, COPI=0, done=0, err=0, and req_ready=0, with state IDLE and counters and frame register cleared.
REQ-026 Reset mid-frame SHALL abort the frame immediately, without a done pulse; the first request after reset SHALL produce a complete, clean frame.
REQ-027 req_ready SHALL rise on the first clk edge after rst_n deasserts.

Configuration
REQ-028 When macro SPI_CONTROLLER_ADDR_CHECK_EN is defined, a request with req_addr > MAX_ADDR SHALL be accepted and SHALL pulse err on the next cycle, with no frame (nCS stays high), no done, and a return to IDLE on the following cycle.
REQ-029 When the macro is undefined, the block SHALL transmit all addresses and tie err to 0.

Structure
REQ-030 Package spi_pkg SHALL hold ADDR_W=7, DATA_W=8, FRAME_W=16, MAX_ADDR=4, WRITE_BIT=1'b1, and the controller state enum.
REQ-031 The SCLK phase counter SHALL be the sub-module spi_clkgen, which emits a phase-done strobe every CLK_DIV cycles when enabled.

Verification
REQ-032 Basic write: addr=0, data=0xA5, CLK_DIV=8 -> nCS low exactly 264 cycles, 16 SCLK rises, bits sampled on rises = 1_0000000_10100101, and one done pulse.
REQ-033 Loopback: connect the outputs to the team's SPI peripheral and write addr=4, data=0x3C -> peripheral data4=0x3C after nCS rises, with other registers unchanged.
REQ-034 Back-to-back: req_valid held high with two requests (addr 1 then 2) -> nCS high for exactly CS_GAP+1 cycles between frames, and both bytes land.
REQ-035 Macro on: addr=5 -> err pulses once, nCS never falls, no done; macro off: a full frame with address bits 0000101.
REQ-036 Reset mid-frame: drive rst_n low during the 7th HIGH phase -> nCS=1 and SCLK=0 in the same cycle with no done; the next request of addr=3, data=0xFF yields a correct frame.
REQ-037 Busy ignore: pulse req_valid during SHIFT -> req_ready=0, and the request is neither transmitted nor queued.
